// File: rtl/traffic_fsm.sv
// Main sequencing FSM of the traffic light controller: lamp sequencing, walk latch,
// reprogrammable intervals. Define TRAFFIC_FSM_DBG_EN to expose state_dbg/time_left.
module traffic_fsm #(
    parameter int T_BASE_DEF = 6,
    parameter int T_EXT_DEF  = 3,
    parameter int T_YEL_DEF  = 2,
    parameter int TW         = 4
) (
    input  logic          clk,
    input  logic          Reset_Sync,
    input  logic          Sensor_Sync,
    input  logic          WR_Sync,
    input  logic          Prog_Sync,
    input  logic          tick_1hz,
    input  logic [1:0]    Time_Param_Selector,
    input  logic [TW-1:0] Time_Value,
    output logic [2:0]    main_lights,
    output logic [2:0]    side_lights,
    output logic          walk_lamp
`ifdef TRAFFIC_FSM_DBG_EN
    ,
    output logic [2:0]    state_dbg,
    output logic [TW-1:0] time_left
`endif
);

    typedef enum logic [2:0] {
        MG1    = 3'd0,
        MG2    = 3'd1,
        MY     = 3'd2,
        WALK   = 3'd3,
        SG     = 3'd4,
        SG_EXT = 3'd5,
        SY     = 3'd6
    } state_t;

    localparam logic [TW-1:0] BASE_D = TW'(T_BASE_DEF);
    localparam logic [TW-1:0] EXT_D  = TW'(T_EXT_DEF);
    localparam logic [TW-1:0] YEL_D  = TW'(T_YEL_DEF);
    localparam logic [TW-1:0] ONE    = TW'(1);

    state_t        state, state_nx;
    logic [TW-1:0] cnt, cnt_nx;
    logic [TW-1:0] t_base, t_base_nx;
    logic [TW-1:0] t_ext, t_ext_nx;
    logic [TW-1:0] t_yel, t_yel_nx;
    logic          walk, walk_nx;
    logic [2:0]    main_nx, side_nx;
    logic          walk_lamp_nx;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        t_base_nx = t_base;
        t_ext_nx  = t_ext;
        t_yel_nx  = t_yel;
        walk_nx   = walk | WR_Sync;

        if (Prog_Sync) begin
            unique case (Time_Param_Selector)
                2'b00:   t_base_nx = (Time_Value == '0) ? BASE_D : Time_Value;
                2'b01:   t_ext_nx  = (Time_Value == '0) ? EXT_D  : Time_Value;
                2'b10:   t_yel_nx  = (Time_Value == '0) ? YEL_D  : Time_Value;
                default: ;
            endcase
            state_nx = MG1;
            cnt_nx   = t_base_nx;
        end else if (tick_1hz) begin
            if (cnt == ONE) begin
                unique case (state)
                    MG1: begin
                        state_nx = MG2;
                        cnt_nx   = Sensor_Sync ? t_ext : t_base;
                    end
                    MG2: begin
                        state_nx = MY;
                        cnt_nx   = t_yel;
                    end
                    MY: begin
                        if (walk) begin
                            state_nx = WALK;
                            cnt_nx   = t_ext;
                            // a request arriving on the clearing edge survives for the next round
                            walk_nx  = WR_Sync;
                        end else begin
                            state_nx = SG;
                            cnt_nx   = t_base;
                        end
                    end
                    WALK: begin
                        state_nx = SG;
                        cnt_nx   = t_base;
                    end
                    SG: begin
                        state_nx = Sensor_Sync ? SG_EXT : SY;
                        cnt_nx   = Sensor_Sync ? t_ext : t_yel;
                    end
                    SG_EXT: begin
                        state_nx = SY;
                        cnt_nx   = t_yel;
                    end
                    default: begin
                        state_nx = MG1;
                        cnt_nx   = t_base;
                    end
                endcase
            end else begin
                cnt_nx = cnt - ONE;
            end
        end
    end

    // Lamps decode the next state so they update with the state register
    always_comb begin
        main_nx      = 3'b100;
        side_nx      = 3'b100;
        walk_lamp_nx = 1'b0;
        unique case (state_nx)
            MG1, MG2:   main_nx = 3'b001;
            MY:         main_nx = 3'b010;
            WALK:       walk_lamp_nx = 1'b1;
            SG, SG_EXT: side_nx = 3'b001;
            SY:         side_nx = 3'b010;
            default:    main_nx = 3'b001;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset_Sync) begin
            state       <= MG1;
            cnt         <= BASE_D;
            t_base      <= BASE_D;
            t_ext       <= EXT_D;
            t_yel       <= YEL_D;
            walk        <= 1'b0;
            main_lights <= 3'b001;
            side_lights <= 3'b100;
            walk_lamp   <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            t_base      <= t_base_nx;
            t_ext       <= t_ext_nx;
            t_yel       <= t_yel_nx;
            walk        <= walk_nx;
            main_lights <= main_nx;
            side_lights <= side_nx;
            walk_lamp   <= walk_lamp_nx;
        end
    end

`ifdef TRAFFIC_FSM_DBG_EN
    always_ff @(posedge clk) begin
        if (Reset_Sync) begin
            state_dbg <= '0;
            time_left <= BASE_D;
        end else begin
            state_dbg <= state_nx;
            time_left <= cnt_nx;
        end
    end
`endif

endmodule

// File: tb/tb_traffic_fsm.sv
// Scoreboard bench for traffic_fsm: expected lamp words are queued per tick and
// compared after each tick is applied.
module tb_traffic_fsm;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          Reset_Sync = 1'b0;
    logic          Sensor_Sync = 1'b0;
    logic          WR_Sync = 1'b0;
    logic          Prog_Sync = 1'b0;
    logic          tick_1hz = 1'b0;
    logic [1:0]    Time_Param_Selector = 2'b11;
    logic [TW-1:0] Time_Value = '0;
    logic [2:0]    main_lights, side_lights;
    logic          walk_lamp;
`ifdef TRAFFIC_FSM_DBG_EN
    logic [2:0]    state_dbg;
    logic [TW-1:0] time_left;
`endif

    always #5 clk = ~clk;

    traffic_fsm #(
        .T_BASE_DEF(6), .T_EXT_DEF(3), .T_YEL_DEF(2), .TW(TW)
    ) dut (
        .clk(clk), .Reset_Sync(Reset_Sync), .Sensor_Sync(Sensor_Sync),
        .WR_Sync(WR_Sync), .Prog_Sync(Prog_Sync), .tick_1hz(tick_1hz),
        .Time_Param_Selector(Time_Param_Selector), .Time_Value(Time_Value),
        .main_lights(main_lights), .side_lights(side_lights), .walk_lamp(walk_lamp)
`ifdef TRAFFIC_FSM_DBG_EN
        , .state_dbg(state_dbg), .time_left(time_left)
`endif
    );

    typedef enum int {S_MG1, S_MG2, S_MY, S_WALK, S_SG, S_SGX, S_SY} st_e;

    logic [6:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    // {main, side, walk}
    function automatic logic [6:0] lamps(st_e s);
        case (s)
            S_MG1, S_MG2: return 7'b001_100_0;
            S_MY:         return 7'b010_100_0;
            S_WALK:       return 7'b100_100_1;
            S_SG, S_SGX:  return 7'b100_001_0;
            default:      return 7'b100_010_0;
        endcase
    endfunction

    task automatic push_seg(input st_e s, input int n);
        repeat (n) exp_q.push_back(lamps(s));
    endtask

    task automatic do_tick(input logic wr);
        @(negedge clk);
        tick_1hz = 1'b1;
        WR_Sync  = wr;
        @(negedge clk);
        tick_1hz = 1'b0;
        WR_Sync  = 1'b0;
        @(negedge clk);
    endtask

    task automatic prog(input logic [1:0] sel, input logic [TW-1:0] val, input logic tk);
        @(negedge clk);
        Prog_Sync = 1'b1;
        Time_Param_Selector = sel;
        Time_Value = val;
        tick_1hz = tk;
        @(negedge clk);
        Prog_Sync = 1'b0;
        Time_Param_Selector = 2'b11;
        Time_Value = '0;
        tick_1hz = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        Reset_Sync = 1'b1;
        Prog_Sync = 1'b1;
        Time_Param_Selector = 2'b10;
        Time_Value = 4'd5;
        tick_1hz = 1'b1;
        WR_Sync = 1'b1;
        Sensor_Sync = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({main_lights, side_lights, walk_lamp} !== 7'b001_100_0) begin
            errors++;
            $display("FAIL reset got=%b exp=%b", {main_lights, side_lights, walk_lamp}, 7'b001_100_0);
        end
        Reset_Sync = 1'b0;
        Prog_Sync = 1'b0;
        Time_Param_Selector = 2'b11;
        Time_Value = '0;
        tick_1hz = 1'b0;
        WR_Sync = 1'b0;
        Sensor_Sync = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_default;
        logic [6:0] e;
        int k = 0;
        push_seg(S_MG1, 6); push_seg(S_MG2, 6); push_seg(S_MY, 2);
        push_seg(S_SG, 6);  push_seg(S_SY, 2);  push_seg(S_MG1, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({main_lights, side_lights, walk_lamp} !== e) begin
                errors++;
                $display("FAIL default tick=%0d got=%b exp=%b", k, {main_lights, side_lights, walk_lamp}, e);
            end
            if (exp_q.size() > 0) begin k++; do_tick(1'b0); end
        end
    endtask

    task automatic test_sensor;
        logic [6:0] e;
        int k = 0;
        Sensor_Sync = 1'b1;
        push_seg(S_MG1, 6); push_seg(S_MG2, 3); push_seg(S_MY, 2);
        push_seg(S_SG, 6);  push_seg(S_SGX, 3); push_seg(S_SY, 2); push_seg(S_MG1, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({main_lights, side_lights, walk_lamp} !== e) begin
                errors++;
                $display("FAIL sensor tick=%0d got=%b exp=%b", k, {main_lights, side_lights, walk_lamp}, e);
            end
            if (exp_q.size() > 0) begin k++; do_tick(1'b0); end
        end
        Sensor_Sync = 1'b0;
    endtask

    task automatic test_walk;
        logic [6:0] e;
        int k = 0;
        @(negedge clk) WR_Sync = 1'b1;
        @(negedge clk) WR_Sync = 1'b0;
        push_seg(S_MG1, 6); push_seg(S_MG2, 6); push_seg(S_MY, 2); push_seg(S_WALK, 3);
        push_seg(S_SG, 6);  push_seg(S_SY, 2);
        push_seg(S_MG1, 6); push_seg(S_MG2, 6); push_seg(S_MY, 2);
        push_seg(S_SG, 6);  push_seg(S_SY, 2);  push_seg(S_MG1, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({main_lights, side_lights, walk_lamp} !== e) begin
                errors++;
                $display("FAIL walk tick=%0d got=%b exp=%b", k, {main_lights, side_lights, walk_lamp}, e);
            end
            if (exp_q.size() > 0) begin k++; do_tick(1'b0); end
        end
    endtask

    task automatic test_walk_same_cycle;
        logic [6:0] e;
        int k = 0;
        @(negedge clk) WR_Sync = 1'b1;
        @(negedge clk) WR_Sync = 1'b0;
        for (int r = 0; r < 2; r++) begin
            push_seg(S_MG1, 6); push_seg(S_MG2, 6); push_seg(S_MY, 2); push_seg(S_WALK, 3);
            push_seg(S_SG, 6);  push_seg(S_SY, 2);
        end
        push_seg(S_MG1, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({main_lights, side_lights, walk_lamp} !== e) begin
                errors++;
                $display("FAIL walk_same tick=%0d got=%b exp=%b", k, {main_lights, side_lights, walk_lamp}, e);
            end
            // tick 14 is the MY->WALK edge of the first round
            if (exp_q.size() > 0) begin k++; do_tick(k == 14); end
        end
    endtask

    task automatic test_prog;
        logic [6:0] e;
        int k = 0;
        push_seg(S_MG1, 6); push_seg(S_MG2, 6); push_seg(S_MY, 2); push_seg(S_SG, 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({main_lights, side_lights, walk_lamp} !== e) begin
                errors++;
                $display("FAIL prog_pre tick=%0d got=%b exp=%b", k, {main_lights, side_lights, walk_lamp}, e);
            end
            if (exp_q.size() > 0) begin k++; do_tick(1'b0); end
        end
        prog(2'b00, 4'd2, 1'b1);
        k = 0;
        push_seg(S_MG1, 2); push_seg(S_MG2, 2); push_seg(S_MY, 2);
        push_seg(S_SG, 2);  push_seg(S_SY, 2);  push_seg(S_MG1, 2); push_seg(S_MG2, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({main_lights, side_lights, walk_lamp} !== e) begin
                errors++;
                $display("FAIL prog_base2 tick=%0d got=%b exp=%b", k, {main_lights, side_lights, walk_lamp}, e);
            end
            if (exp_q.size() > 0) begin k++; do_tick(1'b0); end
        end
        prog(2'b00, 4'd0, 1'b0);
        @(negedge clk);
        Prog_Sync = 1'b1;
        Time_Param_Selector = 2'b11;
        Time_Value = 4'd1;
        for (int c = 0; c < 4; c++) begin
            tick_1hz = c[0];
            @(negedge clk);
            checks++;
            if ({main_lights, side_lights, walk_lamp} !== 7'b001_100_0) begin
                errors++;
                $display("FAIL prog_hold cyc=%0d got=%b exp=%b", c, {main_lights, side_lights, walk_lamp}, 7'b001_100_0);
            end
        end
        Prog_Sync = 1'b0;
        Time_Param_Selector = 2'b11;
        Time_Value = '0;
        tick_1hz = 1'b0;
        k = 0;
        push_seg(S_MG1, 6); push_seg(S_MG2, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({main_lights, side_lights, walk_lamp} !== e) begin
                errors++;
                $display("FAIL prog_restore tick=%0d got=%b exp=%b", k, {main_lights, side_lights, walk_lamp}, e);
            end
            if (exp_q.size() > 0) begin k++; do_tick(1'b0); end
        end
    endtask

    task automatic test_yel_one;
        logic [6:0] e;
        int k = 0;
        prog(2'b10, 4'd1, 1'b0);
        push_seg(S_MG1, 6); push_seg(S_MG2, 6); push_seg(S_MY, 1);
        push_seg(S_SG, 6);  push_seg(S_SY, 1);  push_seg(S_MG1, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({main_lights, side_lights, walk_lamp} !== e) begin
                errors++;
                $display("FAIL yel_one tick=%0d got=%b exp=%b", k, {main_lights, side_lights, walk_lamp}, e);
            end
            if (exp_q.size() > 0) begin k++; do_tick(1'b0); end
        end
        prog(2'b10, 4'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_default;
        test_sensor;
        test_walk;
        test_walk_same_cycle;
        test_prog;
        test_yel_one;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
